// File: rtl/cordic_pkg.sv
// Shared constants, state encoding and arctangent table for the iterative CORDIC unit.
package cordic_pkg;

    localparam logic signed [17:0] K_INIT      = 18'sd39797;
    localparam logic signed [16:0] PI_Q13      = 17'sd25736;
    localparam logic signed [16:0] HALF_PI_Q13 = 17'sd12868;
    localparam logic signed [16:0] TWO_PI_Q13  = 17'sd51472;

    typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_e;

    // atan(2^-i) in Q3.13
    function automatic logic signed [16:0] atan_lut(input logic [3:0] idx);
        logic signed [16:0] v;
        unique case (idx)
            4'd0:    v = 17'sd6434;
            4'd1:    v = 17'sd3798;
            4'd2:    v = 17'sd2007;
            4'd3:    v = 17'sd1019;
            4'd4:    v = 17'sd511;
            4'd5:    v = 17'sd256;
            4'd6:    v = 17'sd128;
            4'd7:    v = 17'sd64;
            4'd8:    v = 17'sd32;
            4'd9:    v = 17'sd16;
            4'd10:   v = 17'sd8;
            4'd11:   v = 17'sd4;
            4'd12:   v = 17'sd2;
            4'd13:   v = 17'sd1;
            default: v = 17'sd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/cordic_micro_rot.sv
// One combinational rotation-mode CORDIC step; direction follows the sign of the residual angle.
module cordic_micro_rot
    import cordic_pkg::*;
(
    input  logic signed [17:0] x_i,
    input  logic signed [17:0] y_i,
    input  logic signed [16:0] z_i,
    input  logic        [3:0]  shift_i,
    output logic signed [17:0] x_o,
    output logic signed [17:0] y_o,
    output logic signed [16:0] z_o
);

    logic signed [17:0] x_sh;
    logic signed [17:0] y_sh;
    logic signed [16:0] atan_v;

    always_comb begin
        x_sh   = x_i >>> shift_i;
        y_sh   = y_i >>> shift_i;
        atan_v = atan_lut(shift_i);
        if (!z_i[16]) begin
            x_o = x_i - y_sh;
            y_o = y_i + x_sh;
            z_o = z_i - atan_v;
        end else begin
            x_o = x_i + y_sh;
            y_o = y_i - x_sh;
            z_o = z_i + atan_v;
        end
    end

endmodule

// File: rtl/cordic.sv
// Iterative sine/cosine generator, one micro-rotation per clock; results held until the next one.
// Define CORDIC_VALID_EN to add a one-cycle 'valid' strobe marking fresh X/Y.
module cordic
    import cordic_pkg::*;
#(
    parameter int unsigned ITERATIONS = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic signed [15:0] Angle,
    output logic signed [15:0] X,
    output logic signed [15:0] Y
`ifdef CORDIC_VALID_EN
    ,
    output logic               valid
`endif
);

    state_e             state_q, state_d;
    logic        [3:0]  cnt_q, cnt_d;
    logic signed [17:0] x_q, x_d, y_q, y_d;
    logic signed [16:0] z_q, z_d;
    logic signed [15:0] x_out_q, x_out_d, y_out_q, y_out_d;
    logic signed [16:0] a_wrap;
    logic signed [17:0] x_rot, y_rot;
    logic signed [16:0] z_rot;

    cordic_micro_rot u_micro_rot (
        .x_i     (x_q),
        .y_i     (y_q),
        .z_i     (z_q),
        .shift_i (cnt_q),
        .x_o     (x_rot),
        .y_o     (y_rot),
        .z_o     (z_rot)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        x_out_d = x_out_q;
        y_out_d = y_out_q;

        a_wrap = {Angle[15], Angle};
        if (a_wrap > PI_Q13) begin
            a_wrap = a_wrap - TWO_PI_Q13;
        end else if (a_wrap < -PI_Q13) begin
            a_wrap = a_wrap + TWO_PI_Q13;
        end

        unique case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = ROTATE;
                    cnt_d   = 4'd0;
                    // Fold |a| > pi/2 onto the right half-plane by starting from (0, +/-K)
                    if (a_wrap > HALF_PI_Q13) begin
                        z_d = a_wrap - HALF_PI_Q13;
                        x_d = 18'sd0;
                        y_d = K_INIT;
                    end else if (a_wrap < -HALF_PI_Q13) begin
                        z_d = a_wrap + HALF_PI_Q13;
                        x_d = 18'sd0;
                        y_d = -K_INIT;
                    end else begin
                        z_d = a_wrap;
                        x_d = K_INIT;
                        y_d = 18'sd0;
                    end
                end
            end
            ROTATE: begin
                x_d = x_rot;
                y_d = y_rot;
                z_d = z_rot;
                if (cnt_q == 4'(ITERATIONS - 1)) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                // Drop the two guard bits with round-half-up
                x_out_d = 16'((x_q + 18'sd2) >>> 2);
                y_out_d = 16'((y_q + 18'sd2) >>> 2);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            x_q     <= 18'sd0;
            y_q     <= 18'sd0;
            z_q     <= 17'sd0;
            x_out_q <= 16'sd0;
            y_out_q <= 16'sd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            x_out_q <= x_out_d;
            y_out_q <= y_out_d;
        end
    end

    assign X = x_out_q;
    assign Y = y_out_q;

`ifdef CORDIC_VALID_EN
    logic valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= (state_q == DONE);
        end
    end

    assign valid = valid_q;
`endif

endmodule

// File: tb/tb_cordic.sv
// Directed bench for cordic: known angles, input-ignore during ROTATE, mid-run reset, back-to-back.
module tb_cordic;

    localparam int ITER = 16;

    logic               clk;
    logic               rst;
    logic               en;
    logic signed [15:0] Angle;
    logic signed [15:0] X;
    logic signed [15:0] Y;
`ifdef CORDIC_VALID_EN
    logic               valid;
`endif

    int n_checks;
    int n_fail;
    int prev_x;
    int prev_y;
    int prev_tol;

    cordic #(
        .ITERATIONS (ITER)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .Angle (Angle),
        .X     (X),
        .Y     (Y)
`ifdef CORDIC_VALID_EN
        ,
        .valid (valid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp, input int tol);
        int diff;
        n_checks++;
        diff = obs - exp;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    // Single computation: en pulse for one edge, hold check at edge N+16, result at N+17.
    task automatic run_angle(input string tag, input logic [15:0] ang, input int ex, input int ey,
                             input bit disturb);
        @(negedge clk);
        Angle = ang;
        en    = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        for (int k = 1; k < ITER + 1; k++) begin
            @(posedge clk);
            #1;
            if (disturb && k == 3) begin
                Angle = 16'h3244;
                en    = 1'b1;
            end
            if (disturb && k == 6) begin
                Angle = 16'hCDBC;
                en    = 1'b0;
            end
        end
        check({tag, "_hold_x"}, int'(X), prev_x, prev_tol);
        check({tag, "_hold_y"}, int'(Y), prev_y, prev_tol);
        @(posedge clk);
        #1;
        check({tag, "_x"}, int'(X), ex, 4);
        check({tag, "_y"}, int'(Y), ey, 4);
`ifdef CORDIC_VALID_EN
        check({tag, "_valid"}, int'(valid), 1, 0);
        @(posedge clk);
        #1;
        check({tag, "_valid_clr"}, int'(valid), 0, 0);
`endif
        prev_x   = ex;
        prev_y   = ey;
        prev_tol = 4;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        prev_x   = 0;
        prev_y   = 0;
        prev_tol = 0;
        rst      = 1'b0;
        en       = 1'b0;
        Angle    = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_x", int'(X), 0, 0);
        check("rst_y", int'(Y), 0, 0);
`ifdef CORDIC_VALID_EN
        check("rst_valid", int'(valid), 0, 0);
`endif
        @(negedge clk);
        rst = 1'b1;

        run_angle("zero",     16'h0000,  16384,      0, 1'b0);
        run_angle("pi_2",     16'h3244,      0,  16384, 1'b0);
        run_angle("m_pi_2",   16'hCDBC,      0, -16384, 1'b0);
        run_angle("pi_4",     16'h1922,  11585,  11585, 1'b0);
        run_angle("m_pi_6",   16'hEF3F,  14189,  -8192, 1'b0);
        run_angle("m_pi",     16'h9B78, -16384,      0, 1'b0);
        run_angle("ignore",   16'h0000,  16384,      0, 1'b1);
        run_angle("pi_4_b",   16'h1922,  11585,  11585, 1'b0);

        // Reset during the 8th ROTATE cycle wipes held outputs immediately.
        @(negedge clk);
        Angle = 16'hEF3F;
        en    = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_x", int'(X), 0, 0);
        check("midrst_y", int'(Y), 0, 0);

        // Fresh pi computation with en held high: results at N+17 and N+35.
        @(negedge clk);
        rst   = 1'b1;
        Angle = 16'h6488;
        en    = 1'b1;
        @(posedge clk);
        repeat (ITER) @(posedge clk);
        #1;
        check("b2b_hold_x", int'(X), 0, 0);
        check("b2b_hold_y", int'(Y), 0, 0);
        @(posedge clk);
        #1;
        check("b2b1_x", int'(X), -16384, 4);
        check("b2b1_y", int'(Y), 0, 4);
        repeat (ITER + 1) @(posedge clk);
        #1;
        check("b2b2_hold_x", int'(X), -16384, 4);
        @(posedge clk);
        #1;
        en = 1'b0;
        check("b2b2_x", int'(X), -16384, 4);
        check("b2b2_y", int'(Y), 0, 4);
`ifdef CORDIC_VALID_EN
        check("b2b2_valid", int'(valid), 1, 0);
`endif
        repeat (4) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
